sr_cmd_sequencer: RTL and testbench
===================================

SR_CMD_SEQUENCER -- requirements
Module: sr_cmd_sequencer

Interface
REQ-001 Parameter DB_CYCLES, default 4: consecutive stable cycles needed to accept a new level on a request input (range 1..255).
REQ-002 Parameter PULSE_CYCLES, default 2: cycles that s or r is held high per command (range 1..255).
REQ-003 Parameter GAP_CYCLES, default 1: cycles with s=r=0 after every pulse before the next command (range 1..255).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 set_req  input  1  raw, asynchronous, bouncy set request.
REQ-007 clr_req  input  1  raw, asynchronous, bouncy clear request.
REQ-008 s  output  1  registered set drive to the downstream SR latch.
REQ-009 r  output  1  registered reset drive to the downstream SR latch.
REQ-010 busy  output  1  high while in DRIVE or GAP.
REQ-011 q_model  output  1  expected downstream latch state after the last completed command.
REQ-012 conflict  output  1  one-cycle pulse when a set command is discarded because it coincides with a clear command.

Function
REQ-013 Each raw input SHALL pass through its own two-flop synchronizer: 2 cycles of latency.
REQ-014 Per input, a debounced level SHALL take the synchronized value only after that value has differed from the current debounced level on DB_CYCLES consecutive edges; any mismatch break SHALL zero the counter.
REQ-015 A 0->1 transition of a debounced level SHALL raise a one-deep pending flag for that input; repeats while pending SHALL merge.
REQ-016 The FSM SHALL have three states: IDLE, DRIVE, GAP.
REQ-017 IDLE -> DRIVE SHALL occur on the edge where any pending flag is set, consuming the flag.
REQ-018 If both flags are pending at that edge, the clear command SHALL win, both flags SHALL clear, and conflict SHALL pulse for one cycle.
REQ-019 In DRIVE, exactly one of s or r SHALL be 1 for PULSE_CYCLES cycles; then DRIVE -> GAP.
REQ-020 In GAP, s=r=0 for GAP_CYCLES cycles; then GAP -> IDLE.
REQ-021 s and r SHALL never be 1 in the same cycle, including across reset and parameter extremes.
REQ-022 Requests arriving during DRIVE or GAP SHALL be held pending and serviced from IDLE; none SHALL be lost except by REQ-018 merging or discard.
REQ-023 q_model SHALL update on the DRIVE -> GAP edge: 1 after set, 0 after clear.
REQ-024 Falling edges of debounced levels SHALL generate no command.

Reset
REQ-025 On rst=1, asynchronously: s=0, r=0, busy=0, q_model=0, conflict=0, FSM=IDLE.
REQ-026 On rst=1, asynchronously: synchronizers, debounced levels, counters and pending flags SHALL all be 0.
REQ-027 Reset asserted during DRIVE SHALL drop s/r the same instant and discard the command; q_model SHALL stay 0.
REQ-028 After release, a request input already held high SHALL produce one command once it is debounced.

Verification (defaults; E0 = first edge sampling set_req=1)
REQ-029 Clean set_req 0->1 held -> s=1 from E6 to E8; r=0 throughout; q_model=1 at E8; busy=0 at E9.
REQ-030 set_req toggling every cycle for 10 cycles, then held 0 -> no s/r pulse; q_model unchanged.
REQ-031 set_req and clr_req rising on the same edge -> one r pulse of 2 cycles; conflict pulses once; q_model=0; s stays 0.
REQ-032 clr_req rising during an s pulse -> set pulse completes; after the 1-cycle gap, r pulses for 2 cycles; q_model 1 then 0.
REQ-033 rst asserted mid-DRIVE of a set -> s=0 immediately; all outputs 0; no pulse after release while inputs are 0.
REQ-034 Assertion over all scenarios -> (s & r) never 1; s/r high-time equals PULSE_CYCLES exactly.

Source files
------------

// File: rtl/sr_cmd_sequencer_if.sv
// Request/drive bundle for the SR command sequencer.
// Master drives raw requests; slave drives the latch outputs.
interface sr_cmd_sequencer_if;
  logic set_req;
  logic clr_req;
  logic s;
  logic r;
  logic busy;
  logic q_model;
  logic conflict;

  modport master (
    output set_req, clr_req,
    input  s, r, busy, q_model, conflict
  );

  modport slave (
    input  set_req, clr_req,
    output s, r, busy, q_model, conflict
  );
endinterface

// File: rtl/sr_cmd_sequencer.sv
// Debounced set/clear requests turned into timed, mutually
// exclusive s/r pulses for a downstream SR latch.
module sr_cmd_sequencer #(
  parameter int unsigned DB_CYCLES    = 4,
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 1
) (
  input logic             clk,
  input logic             rst,
  sr_cmd_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);
  localparam logic [7:0] P_LAST  = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] G_LAST  = 8'(GAP_CYCLES - 1);

  // bit 0 = set path, bit 1 = clear path
  logic [1:0]      meta_q, sync_q;
  logic [1:0]      db_q, db_d;
  logic [1:0][7:0] cnt_q, cnt_d;
  logic [1:0]      rise;
  logic [1:0]      pend_q, pend_d;

  state_t     state_q, state_d;
  logic [7:0] tmr_q, tmr_d;
  logic       cmd_q, cmd_d;
  logic       take;
  logic       s_q, s_d;
  logic       r_q, r_d;
  logic       qm_q, qm_d;
  logic       conf_q, conf_d;

  // Two-flop synchronizers for both raw request inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {bus.clr_req, bus.set_req};
      sync_q <= meta_q;
    end
  end

  // Debounce: accept a new level after DB_CYCLES straight mismatches
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          db_d[i]  = sync_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
    rise = db_d & ~db_q;
  end

  // Debounce and pending-flag state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q   <= '0;
      cnt_q  <= '0;
      pend_q <= '0;
    end else begin
      db_q   <= db_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  // Next state, timer and output decode; clear beats set
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cmd_d   = cmd_q;
    qm_d    = qm_q;
    conf_d  = 1'b0;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|pend_q) begin
          state_d = DRIVE;
          tmr_d   = '0;
          take    = 1'b1;
          cmd_d   = ~pend_q[1];
          conf_d  = &pend_q;
        end
      end
      DRIVE: begin
        if (tmr_q == P_LAST) begin
          state_d = GAP;
          tmr_d   = '0;
          qm_d    = cmd_q;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      GAP: begin
        if (tmr_q == G_LAST) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase
    pend_d = (take ? 2'b00 : pend_q) | rise;
    s_d    = (state_d == DRIVE) &  cmd_d;
    r_d    = (state_d == DRIVE) & ~cmd_d;
  end

  // FSM and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      cmd_q   <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      qm_q    <= 1'b0;
      conf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cmd_q   <= cmd_d;
      s_q     <= s_d;
      r_q     <= r_d;
      qm_q    <= qm_d;
      conf_q  <= conf_d;
    end
  end

  assign bus.s        = s_q;
  assign bus.r        = r_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.q_model  = qm_q;
  assign bus.conflict = conf_q;

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Bench for sr_cmd_sequencer: edge-indexed behavioural model
// plus directed scenarios with literal expectations.
module tb_sr_cmd_sequencer;

  localparam int DB = 4;
  localparam int P  = 2;
  localparam int G  = 1;
  localparam int HN = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sr_cmd_sequencer_if bus();

  sr_cmd_sequencer #(
    .DB_CYCLES(DB),
    .PULSE_CYCLES(P),
    .GAP_CYCLES(G)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // k = index of rising edge since reset release; hist holds the
  // raw input seen at each edge. A command started at edge st
  // drives for edges st..st+P-1, is busy through st+P+G-1,
  // commits q at st+P and frees the sequencer at st+P+G+1.
  bit hist[2][HN];
  int k;
  bit m_db[2];
  bit m_pend[2];
  bit has_cmd;
  int st;
  bit m_cmd, m_conf, m_q;
  bit e_s, e_r, e_busy, e_q, e_conf;

  function automatic bit raw(int i, int idx);
    if (idx < 0 || idx >= HN) return 1'b0;
    return hist[i][idx];
  endfunction

  task automatic model_reset();
    k = -1;
    m_db = '{0, 0};
    m_pend = '{0, 0};
    has_cmd = 0;
    st = 0;
    m_cmd = 0;
    m_conf = 0;
    m_q = 0;
    e_s = 0; e_r = 0; e_busy = 0; e_q = 0; e_conf = 0;
  endtask

  task automatic model_edge();
    bit v, all;
    k++;
    if (k < HN) begin
      hist[0][k] = bus.set_req;
      hist[1][k] = bus.clr_req;
    end
    if ((!has_cmd || k >= st + P + G + 1) && (m_pend[0] || m_pend[1])) begin
      has_cmd = 1;
      st = k;
      m_cmd = !m_pend[1];
      m_conf = m_pend[0] && m_pend[1];
      m_pend = '{0, 0};
    end
    if (has_cmd && k == st + P) m_q = m_cmd;
    for (int i = 0; i < 2; i++) begin
      v = raw(i, k - 2);
      all = 1;
      for (int j = 0; j < DB; j++)
        if (raw(i, k - 2 - j) != v) all = 0;
      if (all && v != m_db[i]) begin
        m_db[i] = v;
        if (v) m_pend[i] = 1;
      end
    end
    e_s    = has_cmd &&  m_cmd && k >= st && k < st + P;
    e_r    = has_cmd && !m_cmd && k >= st && k < st + P;
    e_busy = has_cmd && k >= st && k < st + P + G;
    e_conf = has_cmd && m_conf && k == st;
    e_q    = m_q;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_edge();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("s", bus.s, e_s);
    chk("r", bus.r, e_r);
    chk("busy", bus.busy, e_busy);
    chk("q_model", bus.q_model, e_q);
    chk("conflict", bus.conflict, e_conf);
    chk("s_and_r", bus.s & bus.r, 0);
  end

  // ---------------- pulse monitor ----------------
  int s_rises = 0, r_rises = 0, conf_cnt = 0;
  int slen = 0, rlen = 0;
  always @(negedge clk) begin
    if (rst) begin
      slen = 0;
      rlen = 0;
    end else begin
      if (bus.s) begin
        if (slen == 0) s_rises++;
        slen++;
      end else if (slen != 0) begin
        chk("s_width", slen, P);
        slen = 0;
      end
      if (bus.r) begin
        if (rlen == 0) r_rises++;
        rlen++;
      end else if (rlen != 0) begin
        chk("r_width", rlen, P);
        rlen = 0;
      end
      if (bus.conflict) conf_cnt++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_s();
    for (int n = 0; n < 30 && !bus.s; n++) cycles(1);
    chk("wait_s", bus.s, 1);
  endtask

  // ---------------- directed scenarios ----------------
  int sv[12], rv[12], qv[12], bv[12];
  int s0, r0, c0, any_r;

  initial begin
    bus.set_req = 1'b0;
    bus.clr_req = 1'b0;
    cycles(3);
    chk("rst_s", bus.s, 0);
    chk("rst_r", bus.r, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_q", bus.q_model, 0);
    chk("rst_conf", bus.conflict, 0);
    rst = 1'b0;
    cycles(5);

    // clean set: E0 is the next rising edge
    bus.set_req = 1'b1;
    for (int n = 0; n < 12; n++) begin
      cycles(1);
      sv[n] = bus.s; rv[n] = bus.r;
      qv[n] = bus.q_model; bv[n] = bus.busy;
    end
    chk("clean_s_E5", sv[5], 0);
    chk("clean_s_E6", sv[6], 1);
    chk("clean_s_E7", sv[7], 1);
    chk("clean_s_E8", sv[8], 0);
    chk("clean_q_E7", qv[7], 0);
    chk("clean_q_E8", qv[8], 1);
    chk("clean_busy_E8", bv[8], 1);
    chk("clean_busy_E9", bv[9], 0);
    any_r = 0;
    for (int n = 0; n < 12; n++) any_r |= rv[n];
    chk("clean_no_r", any_r, 0);
    bus.set_req = 1'b0;
    cycles(15);

    // bouncing set never settles
    s0 = s_rises;
    for (int n = 0; n < 10; n++) begin
      bus.set_req = (n % 2 == 0);
      cycles(1);
    end
    bus.set_req = 1'b0;
    cycles(20);
    chk("bounce_no_s", s_rises - s0, 0);
    chk("bounce_q", bus.q_model, 1);

    // simultaneous set and clear: clear wins
    s0 = s_rises; r0 = r_rises; c0 = conf_cnt;
    bus.set_req = 1'b1;
    bus.clr_req = 1'b1;
    cycles(20);
    chk("conf_r_pulses", r_rises - r0, 1);
    chk("conf_s_pulses", s_rises - s0, 0);
    chk("conf_pulses", conf_cnt - c0, 1);
    chk("conf_q", bus.q_model, 0);
    bus.set_req = 1'b0;
    bus.clr_req = 1'b0;
    cycles(15);

    // clear arrives during the set pulse
    s0 = s_rises; r0 = r_rises;
    bus.set_req = 1'b1;
    wait_s();
    bus.clr_req = 1'b1;
    cycles(3);
    chk("seq_q_after_set", bus.q_model, 1);
    cycles(15);
    chk("seq_s_pulses", s_rises - s0, 1);
    chk("seq_r_pulses", r_rises - r0, 1);
    chk("seq_q_after_clr", bus.q_model, 0);
    bus.set_req = 1'b0;
    bus.clr_req = 1'b0;
    cycles(15);

    // debounce boundary: DB-1 wide rejected, DB wide accepted
    r0 = r_rises;
    bus.clr_req = 1'b1;
    cycles(DB - 1);
    bus.clr_req = 1'b0;
    cycles(15);
    chk("db_short", r_rises - r0, 0);
    bus.clr_req = 1'b1;
    cycles(DB);
    bus.clr_req = 1'b0;
    cycles(15);
    chk("db_exact", r_rises - r0, 1);

    // reset in the middle of a set pulse
    s0 = s_rises; r0 = r_rises;
    bus.set_req = 1'b1;
    wait_s();
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_s", bus.s, 0);
    chk("mid_rst_r", bus.r, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_q", bus.q_model, 0);
    chk("mid_rst_conf", bus.conflict, 0);
    bus.set_req = 1'b0;
    cycles(3);
    rst = 1'b0;
    s0 = s_rises;
    cycles(20);
    chk("post_rst_no_s", s_rises - s0, 0);
    chk("post_rst_no_r", r_rises - r0, 0);
    chk("post_rst_q", bus.q_model, 0);

    // request already high while reset releases
    rst = 1'b1;
    bus.set_req = 1'b1;
    cycles(3);
    rst = 1'b0;
    s0 = s_rises;
    cycles(20);
    chk("held_s_pulses", s_rises - s0, 1);
    chk("held_q", bus.q_model, 1);
    bus.set_req = 1'b0;
    cycles(15);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
